// File: rtl/mul_seq_sm_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// master = operand source / result sink side, slave = the multiplier.
interface mul_seq_sm_if #(
  parameter int OP_WIDTH = 8,
  parameter int ID_SIZE  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [OP_WIDTH-1:0]   a_in;
  logic [OP_WIDTH-1:0]   b_in;
  logic                  signed_mode;
  logic [ID_SIZE-1:0]    id_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*OP_WIDTH-1:0] result;
  logic [ID_SIZE-1:0]    id_out;
  logic                  busy;
  logic [1:0]            state;

  modport master (
    output in_valid, a_in, b_in, signed_mode, id_in, out_ready,
    input  in_ready, out_valid, result, id_out, busy, state
  );

  modport slave (
    input  in_valid, a_in, b_in, signed_mode, id_in, out_ready,
    output in_ready, out_valid, result, id_out, busy, state
  );
endinterface

// File: rtl/mul_seq_sm.sv
// Sequential shift-and-add multiplier: magnitudes are multiplied unsigned,
// then the sign is applied in a single correction cycle.
module mul_seq_sm #(
  parameter int OP_WIDTH   = 8,
  parameter int ID_SIZE    = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  mul_seq_sm_if.slave  bus
);
  localparam int N  = OP_WIDTH;
  localparam int W  = 2 * OP_WIDTH;
  localparam int CW = $clog2(OP_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(OP_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [W-1:0]       acc;
  logic [W-1:0]       mcand;
  logic [N-1:0]       mplier;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [ID_SIZE-1:0] id_q;
  logic [W-1:0]       result_q;
  logic [ID_SIZE-1:0] id_out_q;

  logic [N-1:0]       mag_a;
  logic [N-1:0]       mag_b;
  logic [N-1:0]       mplier_sh;
  logic [W-1:0]       acc_add;
  logic               calc_last;
  logic               accept;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE and out_valid only in DONE, so
  // an operation and its result can never transfer on the same edge.
  assign accept = bus.in_valid && (state == S_IDLE);

  always_comb begin
    mag_a     = (bus.signed_mode && bus.a_in[N-1]) ? -bus.a_in : bus.a_in;
    mag_b     = (bus.signed_mode && bus.b_in[N-1]) ? -bus.b_in : bus.b_in;
    mplier_sh = mplier >> 1;
    acc_add   = mplier[0] ? (acc + mcand) : acc;
    // Early exit looks at the multiplier after this cycle's shift.
    calc_last = (cnt == CNT_LAST) || (EARLY_EXIT && (mplier_sh == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      id_q     <= '0;
      result_q <= '0;
      id_out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            neg    <= bus.signed_mode && (bus.a_in[N-1] ^ bus.b_in[N-1]);
            id_q   <= bus.id_in;
            acc    <= '0;
            mcand  <= {{N{1'b0}}, mag_a};
            mplier <= mag_b;
            cnt    <= '0;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt + 1'b1;
          if (calc_last) state <= S_FIX;
        end
        S_FIX: begin
          // Magnitude of the most-negative square is exact in 2N bits; -0 stays 0.
          result_q <= neg ? -acc : acc;
          id_out_q <= id_q;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.result    = result_q;
  assign bus.id_out    = id_out_q;
  assign bus.state     = state;
endmodule

// File: tb/tb_mul_seq_sm.sv
// Bench for mul_seq_sm: directed vector table on N=8 (with and without early
// exit, sharing one input bus), multi-cycle corner sequences, random scoreboard.
module tb_mul_seq_sm;
  logic clk;
  logic rst_n;

  // Shared N=8 input bus feeding both the plain and the early-exit instance
  logic        iv8, or8, sm8;
  logic [7:0]  a8, b8, id8;
  logic        iv16, or16, sm16;
  logic [15:0] a16, b16;
  logic [7:0]  id16;

  int checks   = 0;
  int failures = 0;

  logic [23:0] exp_q8[$];
  logic [39:0] exp_q16[$];

  mul_seq_sm_if #(.OP_WIDTH(8),  .ID_SIZE(8)) if8 ();
  mul_seq_sm_if #(.OP_WIDTH(8),  .ID_SIZE(8)) if8e ();
  mul_seq_sm_if #(.OP_WIDTH(16), .ID_SIZE(8)) if16 ();

  assign if8.in_valid     = iv8;
  assign if8.a_in         = a8;
  assign if8.b_in         = b8;
  assign if8.signed_mode  = sm8;
  assign if8.id_in        = id8;
  assign if8.out_ready    = or8;
  assign if8e.in_valid    = iv8;
  assign if8e.a_in        = a8;
  assign if8e.b_in        = b8;
  assign if8e.signed_mode = sm8;
  assign if8e.id_in       = id8;
  assign if8e.out_ready   = or8;
  assign if16.in_valid    = iv16;
  assign if16.a_in        = a16;
  assign if16.b_in        = b16;
  assign if16.signed_mode = sm16;
  assign if16.id_in       = id16;
  assign if16.out_ready   = or16;

  mul_seq_sm #(.OP_WIDTH(8),  .ID_SIZE(8), .EARLY_EXIT(1'b0)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  mul_seq_sm #(.OP_WIDTH(8),  .ID_SIZE(8), .EARLY_EXIT(1'b1)) dut8e (.clk(clk), .rst_n(rst_n), .bus(if8e));
  mul_seq_sm #(.OP_WIDTH(16), .ID_SIZE(8), .EARLY_EXIT(1'b0)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Independent reference: signed integer multiply, truncated to 2n bits
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sm, input int n);
    longint sa, sb, p;
    logic [63:0] mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[n-1]) sa = sa - (longint'(1) << n);
    if (sm && b[n-1]) sb = sb - (longint'(1) << n);
    p    = sa * sb;
    mask = (64'd1 << (2 * n)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  task automatic xfer8();
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
    chk("xfer_out_valid_drop", 64'(if8.out_valid), 64'd0);
    chk("xfer_in_ready_rise",  64'(if8.in_ready),  64'd1);
  endtask

  task automatic wait_out8(input string name);
    int c;
    c = 0;
    while (!if8.out_valid && c < 40) begin
      @(posedge clk);
      #1 c++;
    end
    chk(name, 64'(if8.out_valid), 64'd1);
  endtask

  // Drives one op on the shared N=8 bus and checks both instances
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic [7:0] id,
                        input logic [15:0] exp_res, input int exp_lat_e);
    int lat8, late;
    @(negedge clk);
    a8 = a; b8 = b; sm8 = sm; id8 = id; iv8 = 1'b1; or8 = 1'b0;
    @(posedge clk);
    #1 iv8 = 1'b0;
    chk({name, "_busy"}, 64'(if8.busy), 64'd1);
    lat8 = 0;
    late = 0;
    for (int c = 1; c <= 30 && (lat8 == 0 || late == 0); c++) begin
      @(posedge clk);
      #1;
      if (if8.out_valid  && lat8 == 0) lat8 = c;
      if (if8e.out_valid && late == 0) late = c;
    end
    chk({name, "_lat"},    64'(lat8), 64'd9);
    chk({name, "_lat_ee"}, 64'(late), 64'(exp_lat_e));
    chk({name, "_res"},    64'(if8.result),  64'(exp_res));
    chk({name, "_id"},     64'(if8.id_out),  64'(id));
    chk({name, "_res_ee"}, 64'(if8e.result), 64'(exp_res));
    chk({name, "_id_ee"},  64'(if8e.id_out), 64'(id));
    xfer8();
  endtask

  // ---------------- random scoreboard processes ----------------
  task automatic src8(input int n_ops);
    int w;
    logic [63:0] e;
    for (int i = 0; i < n_ops; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      w = 0;
      while (!if8.in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!if8.in_ready) begin
        chk("src8_timeout", 64'(if8.in_ready), 64'd1);
        return;
      end
      a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom); id8 = 8'($urandom);
      iv8 = 1'b1;
      e = ref_mul(32'(a8), 32'(b8), sm8, 8);
      exp_q8.push_back({id8, e[15:0]});
      @(posedge clk);
      #1 iv8 = 1'b0;
    end
  endtask

  task automatic sink8(input int n_ops);
    int got, cyc;
    logic [23:0] e;
    got = 0;
    cyc = 0;
    while (got < n_ops && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      or8 = ($urandom_range(0, 3) != 0);
      if (if8.out_valid && or8) begin
        if (exp_q8.size() == 0) begin
          chk("sink8_unexpected", 64'(if8.out_valid), 64'd0);
        end else begin
          e = exp_q8.pop_front();
          chk("rand8_result",    64'({if8.id_out, if8.result}),   64'(e));
          chk("rand8_result_ee", 64'({if8e.id_out, if8e.result}), 64'(e));
        end
        got++;
      end
    end
    or8 = 1'b0;
    chk("sink8_count", 64'(got), 64'(n_ops));
  endtask

  task automatic src16(input int n_ops);
    int w;
    logic [63:0] e;
    for (int i = 0; i < n_ops; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      w = 0;
      while (!if16.in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (!if16.in_ready) begin
        chk("src16_timeout", 64'(if16.in_ready), 64'd1);
        return;
      end
      a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom); id16 = 8'($urandom);
      if ($urandom_range(0, 15) == 0) a16 = 16'h8000;
      iv16 = 1'b1;
      e = ref_mul(32'(a16), 32'(b16), sm16, 16);
      exp_q16.push_back({id16, e[31:0]});
      @(posedge clk);
      #1 iv16 = 1'b0;
    end
  endtask

  task automatic sink16(input int n_ops);
    int got, cyc;
    logic [39:0] e;
    got = 0;
    cyc = 0;
    while (got < n_ops && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      or16 = ($urandom_range(0, 3) != 0);
      if (if16.out_valid && or16) begin
        if (exp_q16.size() == 0) begin
          chk("sink16_unexpected", 64'(if16.out_valid), 64'd0);
        end else begin
          e = exp_q16.pop_front();
          chk("rand16_result", 64'({if16.id_out, if16.result}), 64'(e));
        end
        got++;
      end
    end
    or16 = 1'b0;
    chk("sink16_count", 64'(got), 64'(n_ops));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [7:0]  id;
    logic [15:0] exp;
    int          lat_e;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [15:0] held;
    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 8'h01, 16'hFE01, 9};
    vecs[1]  = '{8'hFD, 8'h05, 1'b1, 8'h02, 16'hFFF1, 4};
    vecs[2]  = '{8'h80, 8'h80, 1'b1, 8'h03, 16'h4000, 9};
    vecs[3]  = '{8'h80, 8'h7F, 1'b1, 8'h04, 16'hC080, 8};
    vecs[4]  = '{8'h12, 8'h01, 1'b0, 8'h05, 16'h0012, 2};
    vecs[5]  = '{8'h34, 8'h00, 1'b0, 8'h06, 16'h0000, 2};
    vecs[6]  = '{8'h03, 8'h80, 1'b0, 8'h07, 16'h0180, 9};
    vecs[7]  = '{8'hFB, 8'h00, 1'b1, 8'h08, 16'h0000, 2};
    vecs[8]  = '{8'h80, 8'h80, 1'b0, 8'h09, 16'h4000, 9};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 8'h0A, 16'h0001, 2};
    vecs[10] = '{8'h7F, 8'hFF, 1'b1, 8'h0B, 16'hFF81, 2};

    rst_n = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0; id8 = '0;
    iv16 = 1'b0; or16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0; id16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  64'(if8.in_ready),  64'd1);
    chk("rst_out_valid", 64'(if8.out_valid), 64'd0);
    chk("rst_busy",      64'(if8.busy),      64'd0);
    chk("rst_result",    64'(if8.result),    64'd0);
    chk("rst_id_out",    64'(if8.id_out),    64'd0);
    chk("rst_state",     64'(if8.state),     64'd0);

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].id,
             vecs[i].exp, vecs[i].lat_e);

    // Back-pressure: result held, extra in_valid ignored, back-to-back accept
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd3; sm8 = 1'b0; id8 = 8'h11; iv8 = 1'b1; or8 = 1'b0;
    @(posedge clk);
    #1 iv8 = 1'b0;
    wait_out8("bp_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h55; id8 = 8'hEE; iv8 = 1'b1;
      held = if8.result;
      chk("bp_out_valid", 64'(if8.out_valid), 64'd1);
      chk("bp_result",    64'(held),          64'd600);
      chk("bp_id",        64'(if8.id_out),    64'h11);
      chk("bp_in_ready",  64'(if8.in_ready),  64'd0);
    end
    @(negedge clk);
    a8 = 8'd12; b8 = 8'd11; sm8 = 1'b0; id8 = 8'h22; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
    chk("bp_xfer_out_valid", 64'(if8.out_valid), 64'd0);
    chk("bp_xfer_in_ready",  64'(if8.in_ready),  64'd1);
    chk("bp_result_kept",    64'(if8.result),    64'd600);
    @(posedge clk);
    #1 iv8 = 1'b0;
    chk("b2b_busy", 64'(if8.busy), 64'd1);
    wait_out8("b2b_wait");
    chk("b2b_result", 64'(if8.result), 64'd132);
    chk("b2b_id",     64'(if8.id_out), 64'h22);
    xfer8();

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; sm8 = 1'b0; id8 = 8'h5A; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(if8.out_valid), 64'd0);
    chk("mid_rst_busy",      64'(if8.busy),      64'd0);
    chk("mid_rst_busy_ee",   64'(if8e.busy),     64'd0);
    chk("mid_rst_result",    64'(if8.result),    64'd0);
    chk("mid_rst_id",        64'(if8.id_out),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 8'd7, 8'd6, 1'b0, 8'h33, 16'd42, 4);

    // Random mixes on N=8 (both instances) and N=16, running concurrently
    fork
      src8(1000);
      sink8(1000);
      src16(1000);
      sink16(1000);
    join
    chk("q8_empty",  64'(exp_q8.size()),  64'd0);
    chk("q16_empty", 64'(exp_q16.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
